apb_responder: RTL and testbench

- APB completer (responder) for the team's APB initiator. Decodes one PSELx line from it and completes write and read transfers with a PREADY handshake and programmable wait states.
- Write data lands in a small FIFO that a local consumer drains.
- Read transfers return a 1-bit status on PRDATA: data pending.
- Sits between the APB initiator's select/enable/data outputs and a downstream byte consumer.

---
 rtl/apb_resp_pkg.sv | 15 +
 rtl/apb_resp_fifo.sv | 67 ++++++
 rtl/apb_responder.sv | 127 ++++++++++++
 tb/tb_apb_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_resp_pkg.sv
// Shared types and defaults for the APB responder and its write FIFO.
package apb_resp_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, WAIT, ACCESS} apb_state_t;

  localparam int DEF_M           = 8;
  localparam int DEF_DEPTH       = 4;
  localparam int DEF_WAIT_CYCLES = 1;

  // Occupancy needs to represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/apb_resp_fifo.sv
// Synchronous FIFO with a registered head word (0 when empty) and registered occupancy.
module apb_resp_fifo
  import apb_resp_pkg::*;
#(
  parameter int m     = DEF_M,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [m-1:0]                  wdata,
  input  logic                          pop,
  output logic [m-1:0]                  head,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          full,
  output logic                          valid
);

  localparam int CW = count_width(DEPTH);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [m-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0] remain, count_next;
  logic [m-1:0]  head_next;
  logic          push_ok, pop_ok;

  assign full  = (count == DEPTH_C);
  assign valid = (count != '0);

  always_comb begin
    push_ok    = push && !full;
    pop_ok     = pop && valid;
    remain     = count - CW'(pop_ok);
    count_next = remain + CW'(push_ok);
    rd_next    = rd_ptr + PW'(pop_ok);
    head_next  = '0;
    // A push into an otherwise empty FIFO becomes the head directly.
    if (push_ok && remain == '0) begin
      head_next = wdata;
    end else if (remain != '0) begin
      head_next = mem[rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_ok);
      rd_ptr <= rd_next;
      count  <= count_next;
      head   <= head_next;
    end
  end

endmodule

// File: rtl/apb_responder.sv
// APB completer: wait-state FSM, write data into a FIFO, reads return "data pending".
// Optional macro APB_RESP_PSLVERR_EN adds PSLVERR and turns full-FIFO stalls into errors.
module apb_responder
  import apb_resp_pkg::*;
#(
  parameter int m           = DEF_M,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic                          PSEL,
  input  logic                          PENABLE,
  input  logic                          PWRITE,
  input  logic [m-1:0]                  PWDATA,
  output logic                          PREADY,
  output logic                          PRDATA,
`ifdef APB_RESP_PSLVERR_EN
  output logic                          PSLVERR,
`endif
  output logic [m-1:0]                  o_data,
  output logic                          o_data_valid,
  input  logic                          i_data_take,
  output logic [count_width(DEPTH)-1:0] o_count,
  output logic                          o_full
);

`ifdef APB_RESP_PSLVERR_EN
  localparam bit ERR_MODE = 1'b1;
`else
  localparam bit ERR_MODE = 1'b0;
`endif

  apb_state_t   state, state_next;
  logic [2:0]   wait_cnt;
  logic         wr_lat;
  logic [m-1:0] data_lat;
  logic         load, dec, finish, push, slot_free;

  always_comb begin
    state_next = state;
    load       = 1'b0;
    dec        = 1'b0;
    finish     = 1'b0;
    slot_free  = !o_full;
    case (state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_next = SETUP;
          load       = 1'b1;
        end
      end
      SETUP: state_next = WAIT;
      WAIT: begin
        if (!PSEL || !PENABLE) begin
          state_next = IDLE;
        end else if (wait_cnt != 3'd0) begin
          dec = 1'b1;
        end else if (!wr_lat || slot_free || ERR_MODE) begin
          state_next = ACCESS;
          finish     = 1'b1;
        end
      end
      ACCESS: begin
        if (PSEL && !PENABLE) begin
          state_next = SETUP;
          load       = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // A full write only reaches ACCESS in error mode, where its data is dropped.
    push = finish && wr_lat && slot_free;
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
      wr_lat   <= 1'b0;
      data_lat <= '0;
      PREADY   <= 1'b0;
      PRDATA   <= 1'b0;
    end else begin
      state  <= state_next;
      PREADY <= finish;
      if (load) begin
        wait_cnt <= 3'(WAIT_CYCLES);
        wr_lat   <= PWRITE;
        data_lat <= PWDATA;
      end else if (dec) begin
        wait_cnt <= wait_cnt - 3'd1;
      end
      if (finish && !wr_lat) begin
        PRDATA <= o_data_valid;
      end
    end
  end

`ifdef APB_RESP_PSLVERR_EN
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      PSLVERR <= 1'b0;
    end else begin
      PSLVERR <= finish && (wr_lat ? !slot_free : !o_data_valid);
    end
  end
`endif

  apb_resp_fifo #(
    .m     (m),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (PCLK),
    .rst_n (PRESET),
    .push  (push),
    .wdata (data_lat),
    .pop   (i_data_take),
    .head  (o_data),
    .count (o_count),
    .full  (o_full),
    .valid (o_data_valid)
  );

endmodule

// File: tb/tb_apb_responder.sv
// Self-checking bench for apb_responder: vector table, scoreboard queue, corner-case sequences.
module tb_apb_responder;
  import apb_resp_pkg::*;

  localparam int M     = 8;
  localparam int DEPTH = 4;
  localparam int WAITC = 1;
  localparam int CW    = count_width(DEPTH);
  localparam int LAT   = 2 + WAITC;

  logic          PCLK, PRESET, PSEL, PENABLE, PWRITE;
  logic [M-1:0]  PWDATA;
  logic          PREADY, PRDATA;
`ifdef APB_RESP_PSLVERR_EN
  logic          PSLVERR;
`endif
  logic [M-1:0]  o_data;
  logic          o_data_valid, i_data_take, o_full;
  logic [CW-1:0] o_count;

  apb_responder #(.m(M), .DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .PCLK         (PCLK),
    .PRESET       (PRESET),
    .PSEL         (PSEL),
    .PENABLE      (PENABLE),
    .PWRITE       (PWRITE),
    .PWDATA       (PWDATA),
    .PREADY       (PREADY),
    .PRDATA       (PRDATA),
`ifdef APB_RESP_PSLVERR_EN
    .PSLVERR      (PSLVERR),
`endif
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .i_data_take  (i_data_take),
    .o_count      (o_count),
    .o_full       (o_full)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [M-1:0] exp_q[$];

  typedef struct {
    bit          wr;
    logic [7:0]  d;
    bit          take;
    bit          exp_rd;
    bit          exp_err;
    int          exp_cnt;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic xfer(input bit wr, input logic [7:0] d,
                      output logic rd, output logic err, output int lat);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PWDATA = d;
    tick;
    PENABLE = 1'b1;
    lat = -1; rd = 1'b0; err = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (PREADY === 1'b1) begin
        lat = i;
        rd  = PRDATA;
`ifdef APB_RESP_PSLVERR_EN
        err = PSLVERR;
`endif
        break;
      end
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    $display("xfer %s data=0x%02h lat=%0d prdata=%0b err=%0b count=%0d",
             wr ? "wr" : "rd", d, lat, rd, err, o_count);
  endtask

  task automatic pop_check(input string name);
    logic [M-1:0] e;
    i_data_take = 1'b1;
    chk({name, "_valid"}, 32'(o_data_valid), 32'd1);
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: got 0x%0h, expected no data (scoreboard empty)", name, o_data);
      e = '0;
    end else begin
      e = exp_q.pop_front();
      chk(name, 32'(o_data), 32'(e));
    end
    $display("pop data=0x%02h expected=0x%02h", o_data, e);
    tick;
    i_data_take = 1'b0;
  endtask

  logic rd, err;
  int   lat;

  initial begin
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PWDATA = '0; i_data_take = 1'b0;

    tbl[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0};
    tbl[1] = '{1'b1, 8'hC9, 1'b0, 1'b0, 1'b0, 1};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1};
    tbl[3] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 2};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0};
    tbl[6] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1};
    tbl[7] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1};

    // Reset state
    #12;
    chk("rst_pready", 32'(PREADY), 32'd0);
    chk("rst_prdata", 32'(PRDATA), 32'd0);
    chk("rst_count",  32'(o_count), 32'd0);
    chk("rst_full",   32'(o_full), 32'd0);
    chk("rst_valid",  32'(o_data_valid), 32'd0);
    chk("rst_data",   32'(o_data), 32'd0);
    @(negedge PCLK);
    PRESET = 1'b1;
    tick;

    // Table-driven transfers
    for (int v = 0; v < 8; v++) begin
      if (tbl[v].take) pop_check("tbl_pop");
      if (tbl[v].wr) exp_q.push_back(tbl[v].d);
      xfer(tbl[v].wr, tbl[v].d, rd, err, lat);
      chk("tbl_latency", 32'(lat), 32'(LAT));
      if (!tbl[v].wr) chk("tbl_prdata", 32'(rd), 32'(tbl[v].exp_rd));
`ifdef APB_RESP_PSLVERR_EN
      chk("tbl_pslverr", 32'(err), 32'(tbl[v].exp_err));
`endif
      chk("tbl_count", 32'(o_count), 32'(tbl[v].exp_cnt));
      if (v == 1) chk("tbl_head_c9", 32'(o_data), 32'h0C9);
      tick;
      chk("tbl_pready_one_cycle", 32'(PREADY), 32'd0);
    end

    // Push and pop on the same edge: FIFO holds A5, write 6B while popping A5
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PWDATA = 8'h6B;
    tick;
    PENABLE = 1'b1;
    repeat (LAT - 1) tick;
    exp_q.push_back(8'h6B);
    pop_check("same_edge_pop");
    chk("same_edge_pready", 32'(PREADY), 32'd1);
    chk("same_edge_count", 32'(o_count), 32'd1);
    chk("same_edge_head", 32'(o_data), 32'h06B);
    PSEL = 1'b0; PENABLE = 1'b0;
    $display("xfer wr data=0x6b with simultaneous pop, count=%0d", o_count);
    tick;

    // Reset asserted while a write is in WAIT
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PWDATA = 8'h77;
    tick;
    PENABLE = 1'b1;
    tick;
    #2 PRESET = 1'b0;
    #1;
    chk("midrst_pready", 32'(PREADY), 32'd0);
    chk("midrst_count", 32'(o_count), 32'd0);
    chk("midrst_valid", 32'(o_data_valid), 32'd0);
    $display("reset during WAIT, count=%0d", o_count);
    PSEL = 1'b0; PENABLE = 1'b0;
    exp_q.delete();
    @(negedge PCLK);
    PRESET = 1'b1;
    repeat (3) tick;
    chk("midrst_no_push", 32'(o_count), 32'd0);

    // Abort by dropping PENABLE in WAIT
    exp_q.push_back(8'h11);
    xfer(1'b1, 8'h11, rd, err, lat);
    chk("abort_pre_lat", 32'(lat), 32'(LAT));
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PWDATA = 8'hEE;
    tick;
    PENABLE = 1'b1;
    tick;
    PSEL = 1'b0; PENABLE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("abort_no_pready", 32'(PREADY), 32'd0);
    end
    chk("abort_count", 32'(o_count), 32'd1);
    $display("abort in WAIT, count=%0d", o_count);
    xfer(1'b0, 8'h00, rd, err, lat);
    chk("abort_post_lat", 32'(lat), 32'(LAT));
    chk("abort_post_prdata", 32'(rd), 32'd1);
    pop_check("abort_pop");

`ifndef APB_RESP_PSLVERR_EN
    // Fill, then stall the fifth write until a pop frees a slot
    for (int i = 1; i <= DEPTH; i++) begin
      exp_q.push_back(8'(i));
      xfer(1'b1, 8'(i), rd, err, lat);
      chk("fill_latency", 32'(lat), 32'(LAT));
      chk("fill_count", 32'(o_count), 32'(i));
    end
    chk("fill_full", 32'(o_full), 32'd1);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PWDATA = 8'h05;
    tick;
    PENABLE = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("stall_pready", 32'(PREADY), 32'd0);
    end
    exp_q.push_back(8'h05);
    pop_check("stall_pop");
    chk("stall_unblock_early", 32'(PREADY), 32'd0);
    tick;
    chk("stall_unblock", 32'(PREADY), 32'd1);
    PSEL = 1'b0; PENABLE = 1'b0;
    chk("stall_count", 32'(o_count), 32'(DEPTH));
    $display("xfer wr data=0x05 after stall, count=%0d", o_count);
    tick;
    for (int i = 0; i < DEPTH; i++) pop_check("drain_pop");
`else
    // Error mode: full write is dropped, empty read flags an error
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(8'hA1 + 8'(i));
      xfer(1'b1, 8'hA1 + 8'(i), rd, err, lat);
      chk("fill_count", 32'(o_count), 32'(i + 1));
    end
    xfer(1'b1, 8'hAA, rd, err, lat);
    chk("err_full_lat", 32'(lat), 32'(LAT));
    chk("err_full_pslverr", 32'(err), 32'd1);
    chk("err_full_count", 32'(o_count), 32'(DEPTH));
    tick;
    chk("err_pslverr_clear", 32'(PSLVERR), 32'd0);
    for (int i = 0; i < DEPTH; i++) pop_check("drain_pop");
    xfer(1'b0, 8'h00, rd, err, lat);
    chk("err_empty_pslverr", 32'(err), 32'd1);
    chk("err_empty_prdata", 32'(rd), 32'd0);
`endif
    chk("end_valid", 32'(o_data_valid), 32'd0);
    chk("end_data", 32'(o_data), 32'd0);
    chk("end_count", 32'(o_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
